// File: rtl/riscv_pkg.sv
// Shared core-wide constants and types used by the instruction memory arbiter.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] IMEM_BASE = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DBG
  } imem_owner_e;

endpackage

// File: rtl/imem_addr_check.sv
// Decides whether a byte address falls inside the imem window and slices its word address.
module imem_addr_check
  import riscv_pkg::*;
#(
  parameter int MEM_ADDR_W = 11
) (
  input  logic [XLEN-1:0]       addr_i,
  output logic                  in_range_o,
  output logic [MEM_ADDR_W-1:0] word_addr_o
);

  logic unused_lsb;

  assign in_range_o  = (addr_i[XLEN-1:MEM_ADDR_W+2] == IMEM_BASE[XLEN-1:MEM_ADDR_W+2]);
  assign word_addr_o = addr_i[MEM_ADDR_W+1:2];
  // Byte offset within a word never reaches the macro.
  assign unused_lsb  = ^addr_i[1:0];

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port imem between fetch and debug: fetch has priority, debug gets a slot
// after MAX_FETCH_STREAK consecutive fetch wins, and responses follow one cycle after the grant.
module imem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int MEM_ADDR_W       = 11,
  parameter int MAX_FETCH_STREAK = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  f_req_i,
  input  logic [XLEN-1:0]       f_addr_i,
  input  logic                  f_flush_i,
  output logic                  f_gnt_o,
  output logic                  f_rvalid_o,
  output logic [XLEN-1:0]       f_rdata_o,
  output logic                  f_err_o,
  output logic                  stall_fetch_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [3:0]            d_be_i,
  input  logic [XLEN-1:0]       d_addr_i,
  input  logic [XLEN-1:0]       d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [XLEN-1:0]       d_rdata_o,
  output logic                  d_err_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  input  logic [XLEN-1:0]       mem_rdata_i
);

  localparam int STREAK_W = $clog2(MAX_FETCH_STREAK + 1);

  logic                  f_in_range, d_in_range;
  logic [MEM_ADDR_W-1:0] f_word, d_word;

  imem_owner_e           owner_q, owner_d;
  logic                  err_q, err_d;
  logic                  wr_q, wr_d;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  streak_full;

  imem_addr_check #(.MEM_ADDR_W(MEM_ADDR_W)) u_f_chk (
    .addr_i      (f_addr_i),
    .in_range_o  (f_in_range),
    .word_addr_o (f_word)
  );

  imem_addr_check #(.MEM_ADDR_W(MEM_ADDR_W)) u_d_chk (
    .addr_i      (d_addr_i),
    .in_range_o  (d_in_range),
    .word_addr_o (d_word)
  );

  assign streak_full = (streak_q == STREAK_W'(MAX_FETCH_STREAK));

  always_comb begin
    f_gnt_o     = 1'b0;
    d_gnt_o     = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    owner_d     = OWN_NONE;
    err_d       = 1'b0;
    wr_d        = 1'b0;
    streak_d    = streak_q;

    // Fetch wins unless debug has been kept waiting for a full streak.
    f_gnt_o = f_req_i & ~(d_req_i & streak_full);
    d_gnt_o = d_req_i & ~f_gnt_o;

    if (f_gnt_o) begin
      mem_en_o   = f_in_range;
      mem_addr_o = f_word;
      owner_d    = OWN_FETCH;
      err_d      = ~f_in_range;
    end else if (d_gnt_o) begin
      mem_en_o   = d_in_range;
      mem_addr_o = d_word;
      owner_d    = OWN_DBG;
      err_d      = ~d_in_range;
      wr_d       = d_we_i;
      if (d_in_range && d_we_i) begin
        mem_we_o    = d_be_i;
        mem_wdata_o = d_wdata_i;
      end
    end

    if (!d_req_i || d_gnt_o) begin
      streak_d = '0;
    end else if (f_gnt_o && !streak_full) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      streak_q <= streak_d;
    end
  end

  assign stall_fetch_o = f_req_i & ~f_gnt_o;

  // A redirect kills only the fetch response landing this cycle; debug is unaffected.
  assign f_rvalid_o = (owner_q == OWN_FETCH) & ~f_flush_i;
  assign f_err_o    = f_rvalid_o & err_q;
  assign f_rdata_o  = !f_rvalid_o ? '0 : (err_q ? NOP_INSTR : mem_rdata_i);

  assign d_rvalid_o = (owner_q == OWN_DBG);
  assign d_err_o    = d_rvalid_o & err_q;
  assign d_rdata_o  = (d_rvalid_o && !err_q && !wr_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed vector table, hand sequences for
// starvation and reset, then constrained-random traffic against a transaction-level model.
module tb_imem_port_arbiter;
  import riscv_pkg::*;

  localparam int DEPTH      = 2048;
  localparam int MAX_STREAK = 8;

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_flush;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
  } stim_t;

  typedef struct {
    logic        f_gnt;
    logic        d_gnt;
    logic        stall;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [10:0] mem_addr;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
  } resp_t;

  typedef struct {
    stim_t s;
    resp_t e;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        f_req_i, f_flush_i, d_req_i, d_we_i;
  logic [31:0] f_addr_i, d_addr_i, d_wdata_i;
  logic [3:0]  d_be_i;
  logic        f_gnt_o, f_rvalid_o, f_err_o, stall_fetch_o;
  logic [31:0] f_rdata_o;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [10:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  logic [31:0] imem      [DEPTH];
  logic [31:0] model_mem [DEPTH];
  int          streak;
  bit          pend_valid, pend_fetch, pend_err, pend_write;
  logic [31:0] pend_data;

  vec_t        tbl [20];

  imem_port_arbiter #(.MEM_ADDR_W(11), .MAX_FETCH_STREAK(MAX_STREAK)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .f_req_i       (f_req_i),
    .f_addr_i      (f_addr_i),
    .f_flush_i     (f_flush_i),
    .f_gnt_o       (f_gnt_o),
    .f_rvalid_o    (f_rvalid_o),
    .f_rdata_o     (f_rdata_o),
    .f_err_o       (f_err_o),
    .stall_fetch_o (stall_fetch_o),
    .d_req_i       (d_req_i),
    .d_we_i        (d_we_i),
    .d_be_i        (d_be_i),
    .d_addr_i      (d_addr_i),
    .d_wdata_i     (d_wdata_i),
    .d_gnt_o       (d_gnt_o),
    .d_rvalid_o    (d_rvalid_o),
    .d_rdata_o     (d_rdata_o),
    .d_err_o       (d_err_o),
    .mem_en_o      (mem_en_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous single-port imem macro with byte enables, read-first.
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) imem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      mem_rdata_i <= imem[mem_addr_o];
    end
  end

  function automatic bit inRange(logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_2000);
  endfunction

  function automatic int wordIdx(logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic resp_t modelPredict(stim_t s);
    resp_t e;
    e = '{default: 0};
    e.f_gnt = s.f_req && (!s.d_req || streak < MAX_STREAK);
    e.d_gnt = s.d_req && !e.f_gnt;
    e.stall = s.f_req && !e.f_gnt;
    if (e.f_gnt && inRange(s.f_addr)) begin
      e.mem_en   = 1'b1;
      e.mem_addr = 11'(wordIdx(s.f_addr));
    end
    if (e.d_gnt && inRange(s.d_addr)) begin
      e.mem_en   = 1'b1;
      e.mem_addr = 11'(wordIdx(s.d_addr));
      e.mem_we   = s.d_we ? s.d_be : 4'h0;
    end
    if (pend_valid && pend_fetch && !s.f_flush) begin
      e.f_rvalid = 1'b1;
      e.f_err    = pend_err;
      e.f_rdata  = pend_err ? 32'h0000_0013 : pend_data;
    end
    if (pend_valid && !pend_fetch) begin
      e.d_rvalid = 1'b1;
      e.d_err    = pend_err;
      e.d_rdata  = (pend_err || pend_write) ? 32'h0 : pend_data;
    end
    return e;
  endfunction

  task automatic stepModel(input stim_t s, output resp_t e);
    logic [31:0] a;
    e = modelPredict(s);
    if (!s.d_req || e.d_gnt)                    streak = 0;
    else if (e.f_gnt && streak < MAX_STREAK)    streak = streak + 1;
    pend_valid = e.f_gnt || e.d_gnt;
    pend_fetch = e.f_gnt;
    a          = e.f_gnt ? s.f_addr : s.d_addr;
    pend_err   = !inRange(a);
    pend_write = e.d_gnt && s.d_we;
    pend_data  = inRange(a) ? model_mem[wordIdx(a)] : 32'h0;
    if (e.d_gnt && s.d_we && inRange(s.d_addr))
      for (int b = 0; b < 4; b++)
        if (s.d_be[b]) model_mem[wordIdx(s.d_addr)][8*b +: 8] = s.d_wdata[8*b +: 8];
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clk_i);
    f_req_i   = s.f_req;
    f_addr_i  = s.f_addr;
    f_flush_i = s.f_flush;
    d_req_i   = s.d_req;
    d_we_i    = s.d_we;
    d_be_i    = s.d_be;
    d_addr_i  = s.d_addr;
    d_wdata_i = s.d_wdata;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input resp_t e);
    checkOutput({tag, ".f_gnt"},    32'(f_gnt_o),       32'(e.f_gnt));
    checkOutput({tag, ".d_gnt"},    32'(d_gnt_o),       32'(e.d_gnt));
    checkOutput({tag, ".stall"},    32'(stall_fetch_o), 32'(e.stall));
    checkOutput({tag, ".mem_en"},   32'(mem_en_o),      32'(e.mem_en));
    checkOutput({tag, ".mem_we"},   32'(mem_we_o),      32'(e.mem_we));
    if (e.mem_en) checkOutput({tag, ".mem_addr"}, 32'(mem_addr_o), 32'(e.mem_addr));
    checkOutput({tag, ".f_rvalid"}, 32'(f_rvalid_o),    32'(e.f_rvalid));
    checkOutput({tag, ".f_rdata"},  f_rdata_o,          e.f_rdata);
    checkOutput({tag, ".f_err"},    32'(f_err_o),       32'(e.f_err));
    checkOutput({tag, ".d_rvalid"}, 32'(d_rvalid_o),    32'(e.d_rvalid));
    checkOutput({tag, ".d_rdata"},  d_rdata_o,          e.d_rdata);
    checkOutput({tag, ".d_err"},    32'(d_err_o),       32'(e.d_err));
  endtask

  function automatic vec_t row(
    input logic fr, input logic [31:0] fa, input logic ff,
    input logic dr, input logic dw, input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd,
    input logic fg, input logic dg, input logic st, input logic en, input logic [3:0] we,
    input logic [10:0] ma, input logic frv, input logic [31:0] frd, input logic fe,
    input logic drv, input logic [31:0] drd, input logic de);
    vec_t v;
    v.s = '{f_req: fr, f_addr: fa, f_flush: ff, d_req: dr, d_we: dw, d_be: db, d_addr: da, d_wdata: dd};
    v.e = '{f_gnt: fg, d_gnt: dg, stall: st, mem_en: en, mem_we: we, mem_addr: ma,
            f_rvalid: frv, f_rdata: frd, f_err: fe, d_rvalid: drv, d_rdata: drd, d_err: de};
    return v;
  endfunction

  function automatic logic [31:0] randAddr();
    if ($urandom_range(0, 9) == 0) return $urandom & 32'h7FFF_FFFC;
    return 32'h8000_0000 + ($urandom_range(0, 31) * 4) + $urandom_range(0, 3);
  endfunction

  initial begin
    stim_t s, idle;
    resp_t e, zero;
    bit    f_hold, d_hold;

    for (int i = 0; i < DEPTH; i++) begin
      imem[i]      = 32'h1000_0000 + i;
      model_mem[i] = 32'h1000_0000 + i;
    end
    idle = '{default: 0};
    zero = '{default: 0};
    streak = 0;
    pend_valid = 0; pend_fetch = 0; pend_err = 0; pend_write = 0; pend_data = 0;

    // Fetch stream, debug write/readback, out-of-range, redirect, debug unaffected by flush.
    tbl[0]  = row(1, 32'h8000_0000, 0, 0, 0, 4'h0, 0, 0,                     1,0,0,1,4'h0,11'd0,  0,32'h0,0,          0,32'h0,0);
    tbl[1]  = row(1, 32'h8000_0004, 0, 0, 0, 4'h0, 0, 0,                     1,0,0,1,4'h0,11'd1,  1,32'h1000_0000,0,  0,32'h0,0);
    tbl[2]  = row(1, 32'h8000_0008, 0, 0, 0, 4'h0, 0, 0,                     1,0,0,1,4'h0,11'd2,  1,32'h1000_0001,0,  0,32'h0,0);
    tbl[3]  = row(0, 0,             0, 0, 0, 4'h0, 0, 0,                     0,0,0,0,4'h0,11'd0,  1,32'h1000_0002,0,  0,32'h0,0);
    tbl[4]  = row(0, 0,             0, 1, 1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, 0,1,0,1,4'hF,11'd4, 0,32'h0,0,       0,32'h0,0);
    tbl[5]  = row(1, 32'h8000_0010, 0, 0, 0, 4'h0, 0, 0,                     1,0,0,1,4'h0,11'd4,  0,32'h0,0,          1,32'h0,0);
    tbl[6]  = row(0, 0,             0, 0, 0, 4'h0, 0, 0,                     0,0,0,0,4'h0,11'd0,  1,32'hDEAD_BEEF,0,  0,32'h0,0);
    tbl[7]  = row(1, 32'h0000_1000, 0, 0, 0, 4'h0, 0, 0,                     1,0,0,0,4'h0,11'd0,  0,32'h0,0,          0,32'h0,0);
    tbl[8]  = row(0, 0,             0, 0, 0, 4'h0, 0, 0,                     0,0,0,0,4'h0,11'd0,  1,32'h0000_0013,1,  0,32'h0,0);
    tbl[9]  = row(1, 32'h8000_0020, 0, 0, 0, 4'h0, 0, 0,                     1,0,0,1,4'h0,11'd8,  0,32'h0,0,          0,32'h0,0);
    tbl[10] = row(1, 32'h8000_0040, 1, 0, 0, 4'h0, 0, 0,                     1,0,0,1,4'h0,11'd16, 0,32'h0,0,          0,32'h0,0);
    tbl[11] = row(0, 0,             0, 0, 0, 4'h0, 0, 0,                     0,0,0,0,4'h0,11'd0,  1,32'h1000_0010,0,  0,32'h0,0);
    tbl[12] = row(0, 0,             0, 1, 0, 4'h0, 32'h8000_0012, 0,         0,1,0,1,4'h0,11'd4,  0,32'h0,0,          0,32'h0,0);
    tbl[13] = row(0, 0,             0, 0, 0, 4'h0, 0, 0,                     0,0,0,0,4'h0,11'd0,  0,32'h0,0,          1,32'hDEAD_BEEF,0);
    tbl[14] = row(0, 0,             0, 1, 0, 4'h0, 32'h0000_0000, 0,         0,1,0,0,4'h0,11'd0,  0,32'h0,0,          0,32'h0,0);
    tbl[15] = row(0, 0,             0, 1, 1, 4'h3, 32'h8000_0014, 32'h1234_5678, 0,1,0,1,4'h3,11'd5, 0,32'h0,0,       1,32'h0,1);
    tbl[16] = row(1, 32'h8000_0014, 0, 0, 0, 4'h0, 0, 0,                     1,0,0,1,4'h0,11'd5,  0,32'h0,0,          1,32'h0,0);
    tbl[17] = row(0, 0,             0, 0, 0, 4'h0, 0, 0,                     0,0,0,0,4'h0,11'd0,  1,32'h1000_5678,0,  0,32'h0,0);
    tbl[18] = row(0, 0,             0, 1, 0, 4'h0, 32'h8000_0000, 0,         0,1,0,1,4'h0,11'd0,  0,32'h0,0,          0,32'h0,0);
    tbl[19] = row(0, 0,             1, 0, 0, 4'h0, 0, 0,                     0,0,0,0,4'h0,11'd0,  0,32'h0,0,          1,32'h1000_0000,0);

    rstn_i = 1'b0;
    f_req_i = 0; f_addr_i = 0; f_flush_i = 0;
    d_req_i = 0; d_we_i = 0; d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
    repeat (3) @(negedge clk_i);
    #1;
    checkAll("reset", zero);
    @(negedge clk_i);
    rstn_i = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i].s);
      stepModel(tbl[i].s, e);
      checkAll($sformatf("vec%0d", i), tbl[i].e);
    end

    // Both requesters held: 8 fetch grants then 1 debug grant, repeating.
    s = '{f_req: 1, f_addr: 32'h8000_0004, f_flush: 0, d_req: 1, d_we: 0, d_be: 4'h0,
          d_addr: 32'h8000_0008, d_wdata: 0};
    for (int i = 0; i < 20; i++) begin
      applyStimulus(s);
      stepModel(s, e);
      checkOutput($sformatf("starve%0d.f_gnt", i), 32'(f_gnt_o),       32'((i % 9) != 8));
      checkOutput($sformatf("starve%0d.stall", i), 32'(stall_fetch_o), 32'((i % 9) == 8));
      checkAll($sformatf("starve%0d", i), e);
    end
    applyStimulus(idle);
    stepModel(idle, e);
    checkAll("starve_tail", e);

    // Reset the cycle after a debug read grant: its response must never appear.
    s = '{f_req: 0, f_addr: 0, f_flush: 0, d_req: 1, d_we: 0, d_be: 4'h0,
          d_addr: 32'h8000_0008, d_wdata: 0};
    applyStimulus(s);
    stepModel(s, e);
    checkOutput("rst_mid.d_gnt", 32'(d_gnt_o), 32'h1);
    @(negedge clk_i);
    rstn_i = 1'b0;
    f_req_i = 0; d_req_i = 0; d_we_i = 0; d_addr_i = 0;
    pend_valid = 0;
    streak = 0;
    #1;
    checkAll("rst_mid.asserted", zero);
    @(negedge clk_i);
    #1;
    checkAll("rst_mid.held", zero);
    @(negedge clk_i);
    rstn_i = 1'b1;
    applyStimulus(idle);
    stepModel(idle, e);
    checkOutput("rst_mid.d_rvalid", 32'(d_rvalid_o), 32'h0);
    checkAll("rst_mid.release", zero);

    // Random traffic; an ungranted requester keeps its request stable.
    s = idle;
    f_hold = 0;
    d_hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!f_hold) begin
        s.f_req  = ($urandom_range(0, 3) != 0);
        s.f_addr = randAddr();
      end
      if (!d_hold) begin
        s.d_req   = ($urandom_range(0, 2) == 0);
        s.d_we    = $urandom_range(0, 1);
        s.d_be    = 4'($urandom_range(0, 15));
        s.d_addr  = randAddr();
        s.d_wdata = $urandom;
      end
      s.f_flush = ($urandom_range(0, 3) == 0);
      applyStimulus(s);
      stepModel(s, e);
      checkAll($sformatf("rand%0d", i), e);
      f_hold = s.f_req && !e.f_gnt;
      d_hold = s.d_req && !e.d_gnt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
